// File: rtl/uart_wb_arbiter_if.sv
// Requester-side and uart-side wishbone signals of the two-port uart register arbiter.
// The arbiter connects through the slave modport; requesters and the uart use master.
interface uart_wb_arbiter_if;
  logic [1:0]  m_stb;
  logic [1:0]  m_we;
  logic [3:0]  m_addr;
  logic [15:0] m_wdata;
  logic [7:0]  m_rdata;
  logic [1:0]  m_ack;
  logic [1:0]  m_err;
  logic [1:0]  wb_addr;
  logic [7:0]  wb_data_in;
  logic [7:0]  wb_data_out;
  logic        wb_we;
  logic        wb_stb;
  logic        wb_ack;
  logic [1:0]  grant;

  modport slave (
    input  m_stb, m_we, m_addr, m_wdata, wb_data_out, wb_ack,
    output m_rdata, m_ack, m_err, wb_addr, wb_data_in, wb_we, wb_stb, grant
  );

  modport master (
    output m_stb, m_we, m_addr, m_wdata, wb_data_out, wb_ack,
    input  m_rdata, m_ack, m_err, wb_addr, wb_data_in, wb_we, wb_stb, grant
  );
endinterface

// File: rtl/uart_wb_arbiter.sv
// Round-robin arbiter sharing the uart wishbone register port between two requesters,
// one transaction in flight, with a per-transaction timeout against a hung slave.
module uart_wb_arbiter #(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CW      = 7
) (
  input logic              clk,
  input logic              reset,
  uart_wb_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t          state, state_n;
  logic            last_grant, last_grant_n;
  logic [CW-1:0]   count, count_n;
  logic [7:0]      rdata, rdata_n;
  logic [1:0]      ack, ack_n;
  logic [1:0]      err, err_n;
  logic [1:0]      addr, addr_n;
  logic [7:0]      wdata, wdata_n;
  logic            we, we_n;
  logic            stb, stb_n;
  logic [1:0]      grant, grant_n;
  logic            win;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= 1'b1;
      count      <= '0;
      rdata      <= '0;
      ack        <= '0;
      err        <= '0;
      addr       <= '0;
      wdata      <= '0;
      we         <= 1'b0;
      stb        <= 1'b0;
      grant      <= '0;
    end else begin
      state      <= state_n;
      last_grant <= last_grant_n;
      count      <= count_n;
      rdata      <= rdata_n;
      ack        <= ack_n;
      err        <= err_n;
      addr       <= addr_n;
      wdata      <= wdata_n;
      we         <= we_n;
      stb        <= stb_n;
      grant      <= grant_n;
    end
  end

  always_comb begin
    state_n      = state;
    last_grant_n = last_grant;
    count_n      = count;
    rdata_n      = rdata;
    ack_n        = '0;
    err_n        = '0;
    addr_n       = addr;
    wdata_n      = wdata;
    we_n         = we;
    stb_n        = stb;
    grant_n      = grant;
    win          = 1'b0;
    case (state)
      IDLE: begin
        if (|bus.m_stb) begin
          // On a tie the requester that did not win last time takes the port.
          win          = (&bus.m_stb) ? ~last_grant : bus.m_stb[1];
          addr_n       = win ? bus.m_addr[3:2]   : bus.m_addr[1:0];
          wdata_n      = win ? bus.m_wdata[15:8] : bus.m_wdata[7:0];
          we_n         = bus.m_we[win];
          stb_n        = 1'b1;
          grant_n      = win ? 2'b10 : 2'b01;
          last_grant_n = win;
          count_n      = '0;
          state_n      = BUSY;
        end
      end
      BUSY: begin
        count_n = count + 1'b1;
        if (bus.wb_ack) begin
          rdata_n = bus.wb_data_out;
          ack_n   = grant;
          stb_n   = 1'b0;
          state_n = DONE;
        end else if (count == CW'(TIMEOUT - 1)) begin
          rdata_n = '0;
          ack_n   = grant;
          err_n   = grant;
          stb_n   = 1'b0;
          state_n = DONE;
        end
      end
      DONE: begin
        grant_n = '0;
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.m_rdata    = rdata;
  assign bus.m_ack      = ack;
  assign bus.m_err      = err;
  assign bus.wb_addr    = addr;
  assign bus.wb_data_in = wdata;
  assign bus.wb_we      = we;
  assign bus.wb_stb     = stb;
  assign bus.grant      = grant;

endmodule
